// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared constants for the two-master round-robin bus arbiter:
//   - FSM state encodings (IDLE, GRANT_M0, GRANT_M1)
//   - master IDs used by the last_served register
//   - hold counter width and its saturation value
// -----------------------------------------------------------------------------
package bus_arb_pkg;
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  localparam int                    HOLD_CNT_W   = 8;
  localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_if
// Request/grant bundle between the two bus masters and the arbiter.
//   M0_req, M1_req     : level requests, held by each master for its transfer
//   M0_grant, M1_grant : registered, mutually exclusive bus ownership
//   bus_busy           : either grant active
//   hold_cnt           : cycles the current owner has held the bus
// Modports:
//   master : requester side (drives requests, observes grants)
//   slave  : arbiter side (observes requests, drives grants)
// -----------------------------------------------------------------------------
interface bus_arbiter_rr_if;
  import bus_arb_pkg::*;

  logic                  M0_req;
  logic                  M1_req;
  logic                  M0_grant;
  logic                  M1_grant;
  logic                  bus_busy;
  logic [HOLD_CNT_W-1:0] hold_cnt;

  modport master (output M0_req, M1_req,
                  input  M0_grant, M1_grant, bus_busy, hold_cnt);
  modport slave  (input  M0_req, M1_req,
                  output M0_grant, M1_grant, bus_busy, hold_cnt);
endinterface

// File: rtl/bus_hold_counter.sv
// -----------------------------------------------------------------------------
// bus_hold_counter
// Saturating hold counter for the current bus owner.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   i_clear : load 0 on the next edge (takes priority over i_en)
//   i_en    : count up by one, sticking at HOLD_CNT_MAX
//   o_cnt   : current count
// -----------------------------------------------------------------------------
module bus_hold_counter
  import bus_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  output logic [HOLD_CNT_W-1:0] o_cnt
);
  logic [HOLD_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_cnt <= '0;
    else if (i_clear)                      r_cnt <= '0;
    else if (i_en && r_cnt != HOLD_CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Two-master round-robin bus arbiter. Grants decode straight from the
// registered FSM state, so they are glitch-free and drop as soon as reset
// asserts. Ownership hands over directly between masters with no idle cycle.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bus_arbiter_rr_if.slave (requests in, grants/busy/hold_cnt out)
// Parameter:
//   MAX_HOLD : grant cycles an owner may keep the bus under contention
// Build option:
//   ARB_HOLD_LIMIT_EN : when defined, an owner that has held the bus for
//                       MAX_HOLD cycles while the other master requests is
//                       forced to hand over. Otherwise hold is unlimited.
// -----------------------------------------------------------------------------
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             reset_n,
  bus_arbiter_rr_if.slave  bus
);
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT_EN = 1'b1;
`else
  localparam bit HOLD_LIMIT_EN = 1'b0;
`endif
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_nxt;
  logic                  r_last;
  logic                  w_both;
  logic                  w_force;
  logic                  w_clear;
  logic [HOLD_CNT_W-1:0] w_hold_cnt;

  assign w_both  = bus.M0_req & bus.M1_req;
  // Owner has used its last allowed cycle while the other master waits.
  assign w_force = HOLD_LIMIT_EN & w_both & (w_hold_cnt == HOLD_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_both)          w_nxt = (r_last == MST_M1) ? GRANT_M0 : GRANT_M1;
        else if (bus.M0_req) w_nxt = GRANT_M0;
        else if (bus.M1_req) w_nxt = GRANT_M1;
        else                 w_nxt = IDLE;
      end
      GRANT_M0: begin
        if (!bus.M0_req)     w_nxt = bus.M1_req ? GRANT_M1 : IDLE;
        else if (w_force)    w_nxt = GRANT_M1;
      end
      GRANT_M1: begin
        if (!bus.M1_req)     w_nxt = bus.M0_req ? GRANT_M0 : IDLE;
        else if (w_force)    w_nxt = GRANT_M0;
      end
      default:               w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= MST_M1;   // M0 wins the first contention after reset
    end else begin
      r_state <= w_nxt;
      if (r_state == GRANT_M0 && w_nxt != GRANT_M0)      r_last <= MST_M0;
      else if (r_state == GRANT_M1 && w_nxt != GRANT_M1) r_last <= MST_M1;
    end
  end

  // Count restarts on any state change and is held at 0 while idle.
  assign w_clear = (w_nxt != r_state) | (w_nxt == IDLE);

  bus_hold_counter u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_en    (1'b1),
    .o_cnt   (w_hold_cnt)
  );

  assign bus.M0_grant = (r_state == GRANT_M0);
  assign bus.M1_grant = (r_state == GRANT_M1);
  assign bus.bus_busy = bus.M0_grant | bus.M1_grant;
  assign bus.hold_cnt = w_hold_cnt;
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Two-master round-robin bus arbiter for the shared system bus.
- Sits in front of the slave address decoder and decides which master (M0 or M1) drives address, data and write-enable onto the bus.
- Grants are registered and mutually exclusive. Ownership passes directly between masters with no idle cycle.
- An optional hold limit forces handoff when one master monopolises the bus while the other is waiting.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one master while the other requests (legal 2..255; used only with ARB_HOLD_LIMIT_EN).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- M0_req  input  1  master 0 bus request, level, held until the transfer ends
- M1_req  input  1  master 1 bus request, level
- M0_grant  output  1  master 0 owns bus (registered)
- M1_grant  output  1  master 1 owns bus (registered)
- bus_busy  output  1  M0_grant | M1_grant
- hold_cnt  output  8  cycles current owner has held the bus, 0 on grant entry, saturates at 255

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; M0_grant=0, M1_grant=0, bus_busy=0, hold_cnt=0.
  - last_served=M1, so M0 wins the first contention.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT_M0, GRANT_M1. Grant outputs decode directly from registered state; bus_busy is combinational from the grants.
- Latency: a request sampled high at edge N gives a grant visible after edge N. Release is also 1 cycle: req low at edge N means the grant is low after edge N.
- IDLE:
  - M0_req only: GRANT_M0.
  - M1_req only: GRANT_M1.
  - Both: grant the master that is not last_served.
  - Neither: stay in IDLE.
- GRANT_M0:
  - M0_req=0 and M1_req=1: go to GRANT_M1 (direct handoff).
  - M0_req=0 and M1_req=0: go to IDLE.
  - M0_req=1: stay, unless the hold limit fires (see Optional Feature).
- GRANT_M1: symmetric to GRANT_M0.
- last_served updates to the owner on every exit from a GRANT state.
- hold_cnt:
  - Cleared to 0 on every transition into a GRANT state and in IDLE.
  - Increments by 1 each cycle the state stays in the same GRANT state; saturates at 255.
- Invariant: M0_grant & M1_grant is never 1, in any cycle including reset release.
- Simultaneous owner drop and other-master raise in the same cycle: direct handoff, no IDLE cycle.
- A request glitch while in IDLE still produces a 1-cycle grant. Masters must hold req; the arbiter does not filter.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN
- Defined: in GRANT_Mx, if both requests are high and hold_cnt == MAX_HOLD-1, the next state is the other GRANT state. The owner therefore holds for exactly MAX_HOLD cycles under contention. Without contention, hold is unlimited.
- Undefined: no forced handoff; the owner keeps the bus until its req drops. MAX_HOLD is ignored; hold_cnt still counts.

Decomposition:
- Shared package/include bus_arb_pkg:
  - state encodings IDLE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10
  - master-ID constants MST_M0=1'b0, MST_M1=1'b1
  - HOLD_CNT_W=8
- One natural sub-module: bus_hold_counter.
  - Inputs: clear and enable.
  - Saturating 8-bit counter with asynchronous active-low reset.
  - Instantiated once for hold_cnt.
- FSM, last_served register and grant decode stay in bus_arbiter_rr.

Test Plan:
1. Reset release with M0_req=1, M1_req=1 at the first edge -> M0_grant=1 after edge 1, M1_grant=0, hold_cnt=0.
2. M0 granted; M0_req drops while M1_req=1 in the same cycle -> next cycle M1_grant=1, M0_grant=0, no cycle with bus_busy=0, hold_cnt=0.
3. Both requests hold high, ARB_HOLD_LIMIT_EN defined, MAX_HOLD=4 -> grants alternate M0 x4 cycles, M1 x4, M0 x4, with hold_cnt sequence 0,1,2,3 per tenure.
4. Same stimulus as 3 with the macro undefined -> M0_grant stays 1 for 300 cycles, hold_cnt saturates at 255, M1_grant never asserts.
5. M1 granted, hold_cnt=5, reset_n pulses low mid-cycle -> M1_grant and hold_cnt are 0 immediately (before the next edge); after release with only M1_req=1, M1 is re-granted after 1 edge.
6. Random req pattern for 10k cycles -> assertion: never M0_grant&M1_grant; every req held high is granted within MAX_HOLD+1 cycles when the macro is defined.
